// File: rtl/mux_pkg.sv
// Shared constants for the channel multiplexer/arbiter.
package mux_pkg;

    localparam logic        MODE_DIRECT    = 1'b0;
    localparam logic        MODE_RR        = 1'b1;
    localparam int unsigned DATA_W         = 16;
    localparam logic [15:0] CONST_VAL_DFLT = 16'h0002;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NCH  = 6,
    localparam int unsigned SELW = $clog2(NCH + 1)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt_onehot,
    output logic [SELW-1:0] gnt_idx,
    output logic            any_gnt
);

    logic [SELW-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        idx        = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            idx = SELW'((int'(ptr) + k) % int'(NCH));
            if (!any_gnt && req[idx]) begin
                any_gnt         = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_mux_arb.sv
// Registered N-channel operand mux with a constant channel, valid/ready handshakes
// and an optional round-robin arbitration mode.
module chan_mux_arb
    import mux_pkg::*;
#(
    parameter int unsigned      WIDTH     = DATA_W,
    parameter int unsigned      NCH       = 6,
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(CONST_VAL_DFLT),
    localparam int unsigned     SELW      = $clog2(NCH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan,
    output logic                 sel_err,
    input  logic                 clr_err
);

    localparam logic [SELW-1:0] CONST_SEL = SELW'(NCH);
    localparam logic [SELW-1:0] LAST_CH   = SELW'(NCH - 1);

    logic [WIDTH-1:0] chan_data [NCH];

    for (genvar i = 0; i < int'(NCH); i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             sel_err_q, sel_err_d;

    logic [NCH-1:0]   gnt_onehot;
    logic [SELW-1:0]  gnt_idx;
    logic             any_gnt;

    logic             load_en;
    logic             xfer;
    logic             err_set;
    logic [WIDTH-1:0] ld_data;
    logic [SELW-1:0]  ld_chan;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .req        (in_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        in_ready = '0;
        xfer     = 1'b0;
        err_set  = 1'b0;
        ld_data  = '0;
        ld_chan  = '0;
        if (mode == MODE_RR) begin
            if (any_gnt) begin
                in_ready = load_en ? gnt_onehot : '0;
                xfer     = load_en;
                ld_data  = chan_data[gnt_idx];
                ld_chan  = gnt_idx;
            end
        end else if (sel < CONST_SEL) begin
            in_ready[sel] = load_en;
            xfer          = in_valid[sel] && load_en;
            ld_data       = chan_data[sel];
            ld_chan       = sel;
        end else if (sel == CONST_SEL) begin
            // Constant channel is always valid and has no upstream ready.
            xfer    = load_en;
            ld_data = CONST_VAL;
            ld_chan = CONST_SEL;
        end else begin
            err_set = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = ld_data;
            out_chan_d  = ld_chan;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (mode == MODE_RR && xfer) begin
            ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
        end
        // Set has priority over clear.
        sel_err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : sel_err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_chan_mux_arb.sv
// Directed self-checking bench for chan_mux_arb (WIDTH=16, NCH=6).
module tb_chan_mux_arb;

    localparam int WIDTH = 16;
    localparam int NCH   = 6;
    localparam int SELW  = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_chan;
    logic                 sel_err;
    logic                 clr_err;

    int n_checks;
    int n_fail;

    chan_mux_arb #(
        .WIDTH     (WIDTH),
        .NCH       (NCH),
        .CONST_VAL (16'h0002)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .sel_err   (sel_err),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_chan(input int i, input logic [WIDTH-1:0] v);
        in_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        for (int i = 0; i < NCH; i++) set_chan(i, 16'h1000 + 16'(i));
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b want 0", out_valid); n_fail++;
        end
        n_checks++;
        if (out_data !== 16'h0000) begin
            $display("FAIL reset_out_data: got %h want 0000", out_data); n_fail++;
        end
        n_checks++;
        if (out_chan !== 3'd0 || sel_err !== 1'b0) begin
            $display("FAIL reset_chan_err: got chan %0d err %b want 0 0", out_chan, sel_err);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        logic [NCH-1:0]   exp_rdy;
        logic [WIDTH-1:0] exp_data;
        mode      = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int s = 0; s <= NCH; s++) begin
            sel     = SELW'(s);
            exp_rdy = (s < NCH) ? NCH'(1 << s) : '0;
            #1;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                $display("FAIL dir_in_ready sel=%0d: got %b want %b", s, in_ready, exp_rdy);
                n_fail++;
            end
            step();
            exp_data = (s < NCH) ? 16'h1000 + 16'(s) : 16'h0002;
            n_checks++;
            if (out_data !== exp_data || out_chan !== SELW'(s) || out_valid !== 1'b1) begin
                $display("FAIL dir_out sel=%0d: got %h chan %0d v %b want %h chan %0d v 1",
                         s, out_data, out_chan, out_valid, exp_data, s);
                n_fail++;
            end
        end
    endtask

    task automatic test_back_pressure();
        sel = 3'd2;
        set_chan(2, 16'hA000);
        step();
        n_checks++;
        if (out_data !== 16'hA000) begin
            $display("FAIL bp_first: got %h want a000", out_data); n_fail++;
        end
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            set_chan(2, 16'hA000 + 16'(k));
            #1;
            n_checks++;
            if (in_ready !== 6'b000000) begin
                $display("FAIL bp_in_ready k=%0d: got %b want 000000", k, in_ready); n_fail++;
            end
            step();
            n_checks++;
            if (out_data !== 16'hA000 || out_chan !== 3'd2 || out_valid !== 1'b1) begin
                $display("FAIL bp_hold k=%0d: got %h chan %0d v %b want a000 chan 2 v 1",
                         k, out_data, out_chan, out_valid);
                n_fail++;
            end
        end
        out_ready = 1'b1;
        set_chan(2, 16'hA00F);
        #1;
        n_checks++;
        if (in_ready !== 6'b000100) begin
            $display("FAIL bp_release_ready: got %b want 000100", in_ready); n_fail++;
        end
        step();
        n_checks++;
        if (out_data !== 16'hA00F) begin
            $display("FAIL bp_release_load: got %h want a00f", out_data); n_fail++;
        end
        set_chan(2, 16'h1002);
    endtask

    task automatic test_round_robin();
        int seq_all [7] = '{0, 1, 2, 3, 4, 5, 0};
        int seq_14 [3]  = '{1, 4, 1};
        mode     = 1'b1;
        sel      = 3'd7;
        in_valid = '1;
        #1;
        n_checks++;
        if (in_ready !== 6'b000001) begin
            $display("FAIL rr_first_ready: got %b want 000001", in_ready); n_fail++;
        end
        for (int k = 0; k < 7; k++) begin
            step();
            n_checks++;
            if (out_chan !== SELW'(seq_all[k]) || out_data !== 16'h1000 + 16'(seq_all[k])) begin
                $display("FAIL rr_all k=%0d: got chan %0d data %h want chan %0d", k, out_chan,
                         out_data, seq_all[k]);
                n_fail++;
            end
        end
        in_valid = 6'b010010;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (out_chan !== SELW'(seq_14[k]) || out_valid !== 1'b1) begin
                $display("FAIL rr_1_4 k=%0d: got chan %0d v %b want chan %0d", k, out_chan,
                         out_valid, seq_14[k]);
                n_fail++;
            end
        end
        n_checks++;
        if (sel_err !== 1'b0) begin
            $display("FAIL rr_no_err: got %b want 0", sel_err); n_fail++;
        end
        in_valid = '0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_chan !== 3'd1) begin
            $display("FAIL rr_idle: got v %b chan %0d want v 0 chan 1", out_valid, out_chan);
            n_fail++;
        end
    endtask

    task automatic test_rr_wrap();
        // ptr is 2 here; grant channel 4 to move ptr to 5.
        in_valid = 6'b010000;
        step();
        n_checks++;
        if (out_chan !== 3'd4) begin
            $display("FAIL wrap_setup: got chan %0d want 4", out_chan); n_fail++;
        end
        in_valid = 6'b000001;
        step();
        n_checks++;
        if (out_chan !== 3'd0 || out_data !== 16'h1000) begin
            $display("FAIL wrap_grant0: got chan %0d data %h want chan 0 data 1000", out_chan,
                     out_data);
            n_fail++;
        end
        in_valid = '1;
        step();
        n_checks++;
        if (out_chan !== 3'd1) begin
            $display("FAIL wrap_ptr1: got chan %0d want 1", out_chan); n_fail++;
        end
    endtask

    task automatic test_error();
        mode = 1'b0;
        sel  = 3'd7;
        #1;
        n_checks++;
        if (in_ready !== 6'b000000) begin
            $display("FAIL err_in_ready: got %b want 000000", in_ready); n_fail++;
        end
        step();
        n_checks++;
        if (sel_err !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h1001) begin
            $display("FAIL err_set: got err %b v %b data %h want err 1 v 0 data 1001", sel_err,
                     out_valid, out_data);
            n_fail++;
        end
        sel = 3'd6;
        step();
        n_checks++;
        if (sel_err !== 1'b1) begin
            $display("FAIL err_hold: got %b want 1", sel_err); n_fail++;
        end
        clr_err = 1'b1;
        step();
        n_checks++;
        if (sel_err !== 1'b0) begin
            $display("FAIL err_clear: got %b want 0", sel_err); n_fail++;
        end
        sel = 3'd7;
        step();
        n_checks++;
        if (sel_err !== 1'b1) begin
            $display("FAIL err_set_wins: got %b want 1", sel_err); n_fail++;
        end
        clr_err = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        sel       = 3'd3;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1003 || sel_err !== 1'b1) begin
            $display("FAIL stall_setup: got v %b data %h err %b want v 1 data 1003 err 1",
                     out_valid, out_data, sel_err);
            n_fail++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_chan !== 3'd0
            || sel_err !== 1'b0) begin
            $display("FAIL async_reset: got v %b data %h chan %0d err %b want all 0",
                     out_valid, out_data, out_chan, sel_err);
            n_fail++;
        end
        @(negedge clk);
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_chan !== 3'd0 || out_valid !== 1'b1) begin
            $display("FAIL rr_restart: got chan %0d v %b want chan 0 v 1", out_chan, out_valid);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        in_data  = '0;
        test_reset();
        test_directed();
        test_back_pressure();
        test_round_robin();
        test_rr_wrap();
        test_error();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_mux_arb.md
# chan_mux_arb

Parametrised, registered N-channel operand multiplexer. It generalises the fixed 16-bit ALU/PC source multiplexers of the multicycle datapath into one block with the following features:
- configurable width and channel count
- a built-in constant channel
- a valid/ready handshake on every input and on the output
- a round-robin arbitration mode for shared-resource ports, such as memory or ALU sharing

It sits between datapath sources and a consuming unit and adds exactly one register stage.

## Interface
- WIDTH, 16, data width of every channel and of the output
- NCH, 6, number of data channels (≥2)
- CONST_VAL, 16'h0002 (WIDTH bits), value supplied by the constant channel
- SELW (localparam), $clog2(NCH+1), select width; select value NCH addresses the constant channel

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = directed (select-driven), 1 = round-robin arbitration
- sel  in  SELW  channel select, used only in directed mode
- in_data  in  NCH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel valid
- in_ready  out  NCH  per-channel ready (combinational)
- out_data  out  WIDTH  registered output data
- out_valid  out  1  registered output valid
- out_ready  in  1  consumer ready
- out_chan  out  SELW  index of the source of the current out_data; NCH means the constant channel
- sel_err  out  1  sticky flag: directed-mode select was out of range (sel > NCH)
- clr_err  in  1  synchronous clear of sel_err

## Operation
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en is high.
- Directed mode:
  - sel < NCH: in_ready[sel] = load_en; all other in_ready = 0. A transfer occurs when in_valid[sel] && load_en.
  - sel == NCH: the constant channel is always valid. When load_en is high, CONST_VAL is loaded and out_chan = NCH. All in_ready = 0.
  - sel > NCH: no load and all in_ready = 0. sel_err is set on the next edge.
- Round-robin mode:
  - ptr (SELW bits) is the highest-priority channel. The grant goes to the first channel with in_valid set, scanning ptr, ptr+1, …, NCH-1, 0, …, ptr-1.
  - in_ready[grant] = load_en; all other in_ready = 0.
  - On a transfer, ptr <= (grant == NCH-1) ? 0 : grant+1.
  - If no input is valid, there is no load and ptr holds.
  - sel is ignored, the constant channel is never granted, and sel_err never sets.
- Output register:
  - On a transfer: out_data, out_chan and out_valid (set to 1) update.
  - Otherwise, if out_valid && out_ready, out_valid clears.
  - Otherwise the output holds; data stays stable while stalled.
- sel_err:
  - Sets on an out-of-range select and clears on clr_err.
  - If the set and clear conditions occur in the same cycle, set wins.
- Mode may change on any cycle and takes effect combinationally in that cycle. ptr is retained across mode changes.
- in_ready may depend on in_valid of other channels. Upstream must not make in_valid depend on in_ready.

## Timing
- Reset (asynchronous assert, synchronous release on the clk domain): out_data = 0, out_valid = 0, out_chan = 0, ptr = 0, sel_err = 0.
- Latency is 1 cycle from input handshake to out_valid.
- Throughput is 1 word per cycle while out_ready stays high.
- While out_valid && !out_ready: all in_ready = 0, and out_data/out_chan are stable.
- If reset asserts mid-stall, the held word is discarded.

## Structure
- Package mux_pkg holds:
  - MODE_DIRECT = 1'b0 and MODE_RR = 1'b1
  - DATA_W = 16
  - default CONST_VAL = 16'h0002
- Sub-module rr_arbiter (parameter NCH):
  - Inputs: req[NCH], ptr.
  - Outputs: gnt_onehot[NCH], gnt_idx, any_gnt.
  - Purely combinational; ptr is owned by chan_mux_arb.

## Test plan
- Directed, NCH=6: in_data channel i = 16'h1000+i, all valid, out_ready = 1, sel stepped 0→6.
  - Required: out_data = 16'h1000…16'h1005, then 16'h0002, each one cycle after its select.
  - Required: out_chan tracks each select.
- Back-pressure: sel = 2, out_ready = 0 for 3 cycles with in_data[2] changing each cycle.
  - Required: out_data stays at the first captured value and in_ready[2] = 0 while stalled.
  - Required: the next word loads on the cycle after out_ready rises.
- Round-robin: all valid, out_ready = 1.
  - Required: out_chan sequence is 0,1,2,3,4,5,0.
  - Then with only channels 1 and 4 valid, the grant alternates 1,4,1.
- Round-robin wrap from ptr = 5: only channel 0 valid, so channel 0 is granted and ptr becomes 1.
- Error: directed sel = 7, then clr_err.
  - Required: no load, sel_err = 1 the next cycle and held, then 0 after clr_err.
  - With sel = 7 and clr_err asserted together, sel_err stays 1.
- Reset: assert rst_n = 0 mid-stall with out_valid = 1.
  - Required: out_valid, out_data, out_chan and sel_err go to 0 immediately, and round-robin restarts at channel 0.
